// File: rtl/clkdiv_controller.sv
// Run-time programmable clock divider: produces a divided clock and a period tick,
// switching divisor or stopping only on period boundaries so no runt pulse appears.
module clkdiv_controller #(
  parameter int DIV_WIDTH   = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div_value,
  input  logic                 div_valid,
  output logic                 div_ready,
  output logic                 clock_out,
  output logic                 tick,
  output logic                 running,
  output logic [DIV_WIDTH-1:0] active_div
);

  typedef enum logic [1:0] {
    ST_STOPPED,
    ST_RUN,
    ST_STOPPING
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
  logic [DIV_WIDTH-1:0] pend_div_q, pend_div_d;
  logic                 pend_valid_q, pend_valid_d;
  logic                 clock_out_q, clock_out_d;
  logic                 tick_q, tick_d;
  logic                 running_q, running_d;

  logic                 active;
  logic                 boundary;
  logic                 xfer;
  logic                 active_next;
  logic [DIV_WIDTH-1:0] div_clamped;

  // Divisors below 2 cannot form a high and a low phase, so they are raised to 2.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] v);
    if (v < DIV_WIDTH'(2)) begin
      return DIV_WIDTH'(2);
    end
    return v;
  endfunction

  assign active      = (state_q != ST_STOPPED);
  assign boundary    = active && (cnt_q == active_div_q - DIV_WIDTH'(1));
  assign xfer        = div_valid && !pend_valid_q;
  assign div_clamped = clamp_div(div_value);

  always_comb begin
    state_d      = state_q;
    active_div_d = active_div_q;
    pend_div_d   = pend_div_q;
    pend_valid_d = pend_valid_q;

    unique case (state_q)
      ST_STOPPED: begin
        if (enable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!enable) state_d = boundary ? ST_STOPPED : ST_STOPPING;
      end
      ST_STOPPING: begin
        if (enable)        state_d = ST_RUN;
        else if (boundary) state_d = ST_STOPPED;
      end
      default: state_d = ST_STOPPED;
    endcase

    // A mid-period divisor waits in pend_div; at a boundary the live transfer
    // wins, which is unambiguous since a transfer implies nothing is pending.
    if (!active || boundary) begin
      if (xfer) begin
        active_div_d = div_clamped;
      end else if (pend_valid_q) begin
        active_div_d = pend_div_q;
        pend_valid_d = 1'b0;
      end
    end else if (xfer) begin
      pend_div_d   = div_clamped;
      pend_valid_d = 1'b1;
    end

    active_next = (state_d != ST_STOPPED);

    if (!active_next || !active || boundary) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    clock_out_d = active_next && (cnt_d < (active_div_d >> 1));
    tick_d      = active_next && (cnt_d == '0);
    running_d   = active_next;
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q      <= ST_STOPPED;
      cnt_q        <= '0;
      active_div_q <= DIV_WIDTH'(DEFAULT_DIV);
      pend_valid_q <= 1'b0;
      clock_out_q  <= 1'b0;
      tick_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_div_q <= active_div_d;
      pend_valid_q <= pend_valid_d;
      clock_out_q  <= clock_out_d;
      tick_q       <= tick_d;
      running_q    <= running_d;
    end
  end

  // Pending payload is qualified by pend_valid_q, so it needs no reset.
  always_ff @(posedge clock_in) begin
    pend_div_q <= pend_div_d;
  end

  assign div_ready  = !pend_valid_q;
  assign clock_out  = clock_out_q;
  assign tick       = tick_q;
  assign running    = running_q;
  assign active_div = active_div_q;

endmodule

// File: tb/tb_clkdiv_controller.sv
// Directed bench for clkdiv_controller: default/odd/clamped divisors, mid-period
// reprogramming, graceful stop/resume, boundary transfer and reset mid-operation.
module tb_clkdiv_controller;

  localparam int DIV_WIDTH = 16;

  logic                 clock_in = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic [DIV_WIDTH-1:0] div_value;
  logic                 div_valid;
  logic                 div_ready;
  logic                 clock_out;
  logic                 tick;
  logic                 running;
  logic [DIV_WIDTH-1:0] active_div;

  int checks = 0;
  int errors = 0;

  clkdiv_controller #(
    .DIV_WIDTH  (DIV_WIDTH),
    .DEFAULT_DIV(4)
  ) dut (
    .clock_in  (clock_in),
    .reset_n   (reset_n),
    .enable    (enable),
    .div_value (div_value),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clock_out (clock_out),
    .tick      (tick),
    .running   (running),
    .active_div(active_div)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock_in);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic c_e, input logic t_e, input logic r_e);
    chk({tag, ".clock_out"}, 32'(clock_out), 32'(c_e));
    chk({tag, ".tick"},      32'(tick),      32'(t_e));
    chk({tag, ".running"},   32'(running),   32'(r_e));
  endtask

  // k counts cycles from the first tick of a period of length n
  task automatic chk_wave(input string tag, input int k, input int n);
    chk_out(tag, (k % n) < (n / 2), (k % n) == 0, 1'b1);
    chk({tag, ".active_div"}, 32'(active_div), 32'(n));
  endtask

  task automatic load_stopped(input int v);
    div_value = DIV_WIDTH'(v);
    div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    div_value = DIV_WIDTH'(9);
    div_valid = 1'b1;
    cyc();
    chk_out("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.active_div", 32'(active_div), 32'd4);
    chk("reset.div_ready", 32'(div_ready), 32'd1);
    reset_n   = 1'b1;
    enable    = 1'b0;
    div_valid = 1'b0;
    cyc();
    chk_out("idle", 1'b0, 1'b0, 1'b0);

    // Default run, N = 4
    enable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cyc();
      chk_wave("def", k, 4);
    end
    enable = 1'b0;
    cyc();
    chk_out("def_stop", 1'b0, 1'b0, 1'b0);

    // Odd divisor loaded while stopped
    load_stopped(5);
    chk("odd.load", 32'(active_div), 32'd5);
    chk("odd.running", 32'(running), 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk_wave("odd", k, 5);
    end
    enable = 1'b0;
    cyc();
    chk_out("odd_stop", 1'b0, 1'b0, 1'b0);

    // Mid-period reprogram 4 -> 6 at cnt = 1
    load_stopped(4);
    enable = 1'b1;
    cyc();
    cyc();
    chk_wave("mid.c1", 1, 4);
    div_value = DIV_WIDTH'(6);
    div_valid = 1'b1;
    cyc();
    chk_out("mid.c2", 1'b0, 1'b0, 1'b1);
    chk("mid.c2.ready", 32'(div_ready), 32'd0);
    div_value = DIV_WIDTH'(3);
    cyc();
    chk_out("mid.c3", 1'b0, 1'b0, 1'b1);
    chk("mid.c3.ready", 32'(div_ready), 32'd0);
    chk("mid.c3.div", 32'(active_div), 32'd4);
    cyc();
    for (int k = 0; k < 12; k++) begin
      if (k > 0) cyc();
      chk_wave("mid.new", k, 6);
      if (k == 0) begin
        chk("mid.ready_back", 32'(div_ready), 32'd1);
        div_valid = 1'b0;
      end
    end
    enable = 1'b0;
    cyc();
    chk_out("mid_stop", 1'b0, 1'b0, 1'b0);

    // Clamp of 0 and 1 to 2
    load_stopped(0);
    chk("clamp0", 32'(active_div), 32'd2);
    load_stopped(7);
    load_stopped(1);
    chk("clamp1", 32'(active_div), 32'd2);
    enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_wave("clamp", k, 2);
    end
    enable = 1'b0;
    cyc();
    chk_out("clamp_stop", 1'b0, 1'b0, 1'b0);

    // Graceful stop: drop enable at cnt = 1
    load_stopped(4);
    enable = 1'b1;
    cyc();
    cyc();
    enable = 1'b0;
    cyc();
    chk_out("stop.c2", 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("stop.c3", 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("stop.end", 1'b0, 1'b0, 1'b0);
    cyc();
    chk_out("stop.hold", 1'b0, 1'b0, 1'b0);

    // Resume: drop at cnt = 1, re-raise at cnt = 2
    enable = 1'b1;
    cyc();
    cyc();
    enable = 1'b0;
    cyc();
    chk_out("resume.c2", 1'b0, 1'b0, 1'b1);
    enable = 1'b1;
    cyc();
    chk_out("resume.c3", 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_wave("resume", k, 4);
    end
    enable = 1'b0;
    cyc();
    chk_out("resume_stop", 1'b0, 1'b0, 1'b0);

    // Reset while N = 6 runs with 3 pending
    load_stopped(6);
    enable = 1'b1;
    cyc();
    cyc();
    div_value = DIV_WIDTH'(3);
    div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
    chk("rst.pend_ready", 32'(div_ready), 32'd0);
    chk_wave("rst.c2", 2, 6);
    reset_n = 1'b0;
    cyc();
    chk_out("rst.mid", 1'b0, 1'b0, 1'b0);
    chk("rst.mid.div", 32'(active_div), 32'd4);
    chk("rst.mid.ready", 32'(div_ready), 32'd1);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk_wave("rst.after", k, 4);
    end

    // Transfer exactly on a boundary applies to the next period at once
    div_value = DIV_WIDTH'(5);
    div_valid = 1'b1;
    cyc();
    div_valid = 1'b0;
    chk_wave("bnd", 0, 5);
    chk("bnd.ready", 32'(div_ready), 32'd1);
    for (int k = 1; k < 10; k++) begin
      cyc();
      chk_wave("bnd", k, 5);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
